// File: rtl/ad_pkg.sv
// Shared constants for the ADC scan path: FSM state codes, default
// geometry and the serial clock divider shared with sclk_gen.
package ad_pkg;

  typedef logic [2:0] ad_state_t;

  localparam ad_state_t ST_IDLE  = 3'd0;
  localparam ad_state_t ST_CONV  = 3'd1;
  localparam ad_state_t ST_SYNC  = 3'd2;
  localparam ad_state_t ST_SHIFT = 3'd3;
  localparam ad_state_t ST_STORE = 3'd4;
  localparam ad_state_t ST_NEXT  = 3'd5;
  localparam ad_state_t ST_FIN   = 3'd6;

  localparam int DATA_W_DEF   = 16;
  localparam int CH_NUM_DEF   = 4;
  localparam int CH_W_DEF     = 2;
  localparam int CONV_CYC_DEF = 20;
  localparam int DIV          = 4;

endpackage

// File: rtl/ad_scan_ctrl_if.sv
// Signal bundle between the scan controller, sclk_gen, the ADC pins and
// the sample sink. The controller is the master.
interface ad_scan_ctrl_if
  import ad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH_W   = CH_W_DEF
) ();

  logic              start;
  logic              sclk;
  logic              pluse;
  logic              ad_sdo;
  logic              ad_convst;
  logic              ad_cs_n;
  logic              ad_sclk;
  logic [CH_W-1:0]   ch_idx;
  logic [DATA_W-1:0] data;
  logic              data_vld;
  logic              busy;
  logic              done;

  modport master (
    input  start, sclk, pluse, ad_sdo,
    output ad_convst, ad_cs_n, ad_sclk, ch_idx, data, data_vld, busy, done
  );

  modport slave (
    output start, sclk, pluse, ad_sdo,
    input  ad_convst, ad_cs_n, ad_sclk, ch_idx, data, data_vld, busy, done
  );

endinterface

// File: rtl/ad_shift_rx.sv
// MSB-first serial receiver: shifts sdi in on each enable and flags the
// enable that completes a DATA_W-bit word.
module ad_shift_rx #(
  parameter int DATA_W = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              sdi,
  output logic [DATA_W-1:0] word,
  output logic              last
);

  localparam int BW = $clog2(DATA_W + 1);

  logic [BW-1:0] bit_cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (en) begin
      // truncating the concatenation drops the old MSB, also valid for DATA_W=1
      word    <= DATA_W'({word, sdi});
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign last = en && (bit_cnt == BW'(DATA_W - 1));

endmodule

// File: rtl/ad_scan_ctrl.sv
// ADC scan sequencer: converts and reads CH_NUM channels in turn, gating
// the sclk_gen clock onto the ADC only while bits are being shifted.
//
// state | meaning
// IDLE  | waiting for start
// CONV  | ad_convst high, conversion timer running
// SYNC  | chip selected, waiting for sclk phase alignment (first pluse)
// SHIFT | ad_sclk enabled, one bit sampled per pluse
// STORE | word complete, latch into data
// NEXT  | data_vld out, advance channel or finish
// FIN   | done strobe, back to IDLE
module ad_scan_ctrl
  import ad_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CH_NUM   = CH_NUM_DEF,
  parameter int CH_W     = CH_W_DEF,
  parameter int CONV_CYC = CONV_CYC_DEF
) (
  input  logic           clk_sys,
  input  logic           rst_n,
  ad_scan_ctrl_if.master bus
);

  localparam int CVW = $clog2(CONV_CYC + 1);

  ad_state_t         state;
  ad_state_t         state_nxt;
  logic [CVW-1:0]    conv_cnt;
  logic [DATA_W-1:0] word;
  logic              last;
  logic              sh_en;
  logic              sh_clr;
  logic              ch_last;
  logic              cs_n_q;
  logic              busy_q;
  logic              vld_q;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] data_q;

  assign sh_en   = bus.pluse && (state == ST_SHIFT);
  assign sh_clr  = (state == ST_SYNC);
  assign ch_last = (ch_q == CH_W'(CH_NUM - 1));

  ad_shift_rx #(.DATA_W(DATA_W)) u_shift_rx (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (sh_clr),
    .en      (sh_en),
    .sdi     (bus.ad_sdo),
    .word    (word),
    .last    (last)
  );

  // cs_n and busy are registered decodes of the next state, so they change
  // on the same edge as the state and never glitch
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      conv_cnt <= '0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      ch_q     <= '0;
      data_q   <= '0;
    end else begin
      state  <= state_nxt;
      cs_n_q <= !(state_nxt inside {ST_SYNC, ST_SHIFT, ST_STORE});
      busy_q <= (state_nxt != ST_IDLE);
      vld_q  <= (state == ST_STORE);
      if (state_nxt == ST_CONV && state != ST_CONV)
        conv_cnt <= CVW'(CONV_CYC - 1);
      else if (state == ST_CONV && conv_cnt != '0)
        conv_cnt <= conv_cnt - 1'b1;
      if (state == ST_IDLE && bus.start)
        ch_q <= '0;
      else if (state == ST_NEXT && !ch_last)
        ch_q <= ch_q + 1'b1;
      if (state == ST_STORE)
        data_q <= word;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start)       state_nxt = ST_CONV;
      ST_CONV:  if (conv_cnt == '0)  state_nxt = ST_SYNC;
      ST_SYNC:  if (bus.pluse)       state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)            state_nxt = ST_STORE;
      ST_STORE:                      state_nxt = ST_NEXT;
      ST_NEXT:                       state_nxt = ch_last ? ST_FIN : ST_CONV;
      ST_FIN:                        state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ad_convst = (state == ST_CONV);
    bus.done      = (state == ST_FIN);
    bus.ad_sclk   = (state == ST_SHIFT) ? bus.sclk : 1'b1;
    bus.ad_cs_n   = cs_n_q;
    bus.busy      = busy_q;
    bus.data_vld  = vld_q;
    bus.ch_idx    = ch_q;
    bus.data      = data_q;
  end

endmodule

// File: doc/ad_scan_ctrl.md
Name: ad_scan_ctrl

Overview:
- Sequences one ADC scan across CH_NUM channels.
- Per channel: pulses conversion start, waits the conversion time, then gates the serial clock from sclk_gen and shifts in DATA_W bits MSB-first.
- Sits in ad_top between sclk_gen (consumes its sclk/pluse) and the sample sink (data/data_vld), started by the system controller.

Parameters:
DATA_W, 16, bits per ADC sample (1..31)
CH_NUM, 4, channels per scan (1..2**CH_W)
CH_W, 2, width of channel index
CONV_CYC, 20, clk_sys cycles ad_convst is held high (>=1)

Ports:
clk_sys  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle scan request
sclk  in  1  free-running serial clock from sclk_gen (idles high)
pluse  in  1  one-cycle strobe from sclk_gen, once per sclk period, cycle before sclk rises
ad_sdo  in  1  ADC serial data
ad_convst  out  1  ADC conversion start
ad_cs_n  out  1  ADC chip select, active low
ad_sclk  out  1  gated serial clock to ADC
ch_idx  out  CH_W  channel being converted/read
data  out  DATA_W  last received sample
data_vld  out  1  one-cycle strobe, data/ch_idx valid
busy  out  1  scan in progress
done  out  1  one-cycle strobe at scan end

Behaviour:
- Clock/reset: one clock, clk_sys. rst_n is asynchronous, active-low; it clears every register.
- Reset values: ad_convst=0, ad_cs_n=1, ch_idx=0, data=0, data_vld=0, busy=0, done=0, state=IDLE.
- ad_sclk is combinational: sclk while state==SHIFT, else 1.
- FSM states: IDLE, CONV, SYNC, SHIFT, STORE, NEXT, FIN.
- IDLE: on start=1 -> CONV; ch_idx<=0, busy<=1.
- CONV: ad_convst=1 for exactly CONV_CYC cycles (the first is the cycle after start is sampled); down-counter; then -> SYNC.
- SYNC: ad_cs_n<=0; wait for the first pluse -> SHIFT, bit counter <= 0. That pluse does not sample.
- SHIFT: on each pluse, shift register <= {sr[DATA_W-2:0], ad_sdo}, bit counter +1. After the DATA_W-th sample -> STORE.
- STORE: data<=shift register; data_vld=1 for one cycle; ad_cs_n<=1 -> NEXT.
- NEXT: if ch_idx==CH_NUM-1 -> FIN; else ch_idx+1 -> CONV.
- FIN: done=1 for one cycle; busy<=0 -> IDLE. ch_idx holds its last value until the next start.
- start while busy=1 is ignored (no queueing). start on the same cycle as FIN is ignored.
- busy is 1 from the cycle after start through the FIN cycle inclusive.
- Bit counter width is clog2(DATA_W+1). Sample count is exact, with no off-by-one at DATA_W.
- pluse arriving in any state other than SYNC/SHIFT has no effect.
- Reset asserted mid-scan immediately returns all outputs to reset values. No partial data_vld is issued.
- Per-channel timing with sclk_gen DIV=4: CONV_CYC + SYNC wait (1..4) + 4*DATA_W + 2 (STORE, NEXT) cycles.

Decomposition:
- Shared package ad_pkg: FSM state encoding localparams (3-bit), default DATA_W/CH_NUM/CONV_CYC, DIV=4 constant shared with sclk_gen.
- Sub-module ad_shift_rx: shift register + bit counter.
  - Inputs: clk_sys, rst_n, clr, en (pluse & state==SHIFT), sdi.
  - Outputs: word[DATA_W-1:0], last (counter==DATA_W-1 & en).
- Top keeps the FSM and the convst/ch counters.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT -> next edge ad_cs_n=1, ad_convst=0, busy=0, ad_sclk=1, no data_vld/done; then start works normally.
- Single channel (CH_NUM=1, DATA_W=16, CONV_CYC=20, DIV=4): drive ad_sdo with 16'hA5C3 MSB-first on the bits sampled at pluse -> data=16'hA5C3, data_vld one cycle, done the cycle after NEXT, ad_convst high exactly 20 cycles.
- Four-channel scan: ADC model returns 16'h1000+ch -> four data_vld strobes with ch_idx 0,1,2,3 and data 1000..1003; one done; ad_cs_n high between channels.
- Clock gating: count ad_sclk rising edges while ad_cs_n=0 -> exactly 16 per channel. ad_sclk stays high in IDLE/CONV/SYNC/STORE.
- start while busy=1 (mid-CONV and mid-SHIFT), and start on the FIN cycle -> ignored: exactly CH_NUM data_vld and one done.
- Boundary widths: DATA_W=1 and DATA_W=31 -> correct bit count and MSB alignment; CONV_CYC=1 -> ad_convst high for 1 cycle.
